// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and sequencer state encoding.
// Pure declarations: no latency, no flow control.
package alu_pkg;

    localparam logic [4:0] OP_INC = 5'h01;
    localparam logic [4:0] OP_DEC = 5'h02;
    localparam logic [4:0] OP_ADD = 5'h03;
    localparam logic [4:0] OP_ADC = 5'h04;
    localparam logic [4:0] OP_SUB = 5'h05;
    localparam logic [4:0] OP_SBB = 5'h06;
    localparam logic [4:0] OP_AND = 5'h07;
    localparam logic [4:0] OP_OR  = 5'h08;
    localparam logic [4:0] OP_XOR = 5'h09;
    localparam logic [4:0] OP_NOT = 5'h0A;
    localparam logic [4:0] OP_SHL = 5'h10;
    localparam logic [4:0] OP_SHR = 5'h11;
    localparam logic [4:0] OP_SAL = 5'h12;
    localparam logic [4:0] OP_SAR = 5'h13;
    localparam logic [4:0] OP_ROL = 5'h14;
    localparam logic [4:0] OP_ROR = 5'h15;
    localparam logic [4:0] OP_RCL = 5'h16;
    localparam logic [4:0] OP_RCR = 5'h17;

    localparam int FLAG_C  = 5;
    localparam int FLAG_Z  = 4;
    localparam int FLAG_N  = 3;
    localparam int FLAG_V  = 2;
    localparam int FLAG_P  = 1;
    localparam int FLAG_AC = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [4:0] op);
        return ((op >= OP_INC) && (op <= OP_NOT)) || ((op >= OP_SHL) && (op <= OP_RCR));
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// 16-bit ALU: arithmetic, logic and single-step shift/rotate with 6-bit status.
// Purely combinational, zero latency; no flow control.
// P is set for even parity over the whole 16-bit result.
module alu
    import alu_pkg::*;
(
    input  logic [4:0]  f,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] result,
    output logic [5:0]  status
);

    logic [15:0] y;
    logic        ci;
    logic        inv;
    logic        arith;
    logic [16:0] sum;
    logic [4:0]  nib;
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        ac;

    // Subtraction runs through the adder as a + ~b + ~borrow; carries are inverted back to borrows.
    always_comb begin
        y     = 16'h0000;
        ci    = 1'b0;
        inv   = 1'b0;
        arith = 1'b0;
        case (f)
            OP_INC: begin y = 16'h0001; arith = 1'b1; end
            OP_DEC: begin y = 16'hFFFF; arith = 1'b1; inv = 1'b1; end
            OP_ADD: begin y = b; arith = 1'b1; end
            OP_ADC: begin y = b; ci = cin; arith = 1'b1; end
            OP_SUB: begin y = ~b; ci = 1'b1; inv = 1'b1; arith = 1'b1; end
            OP_SBB: begin y = ~b; ci = ~cin; inv = 1'b1; arith = 1'b1; end
            default: ;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, y} + {16'h0000, ci};
    assign nib = {1'b0, a[3:0]} + {1'b0, y[3:0]} + {4'h0, ci};

    always_comb begin
        r  = 16'h0000;
        c  = 1'b0;
        v  = 1'b0;
        ac = 1'b0;
        if (arith) begin
            r  = sum[15:0];
            c  = sum[16] ^ inv;
            ac = nib[4] ^ inv;
            v  = (a[15] == y[15]) && (r[15] != a[15]);
        end else begin
            case (f)
                OP_AND: r = a & b;
                OP_OR:  r = a | b;
                OP_XOR: r = a ^ b;
                OP_NOT: r = ~a;
                OP_SHL, OP_SAL: begin r = {a[14:0], 1'b0};  c = a[15]; end
                OP_SHR: begin r = {1'b0, a[15:1]};  c = a[0]; end
                OP_SAR: begin r = {a[15], a[15:1]}; c = a[0]; end
                OP_ROL: begin r = {a[14:0], a[15]}; c = a[15]; end
                OP_ROR: begin r = {a[0], a[15:1]};  c = a[0]; end
                OP_RCL: begin r = {a[14:0], cin};   c = a[15]; end
                OP_RCR: begin r = {cin, a[15:1]};   c = a[0]; end
                default: ;
            endcase
            if (f[4]) begin
                v = r[15] ^ a[15];
            end
        end
    end

    assign result = r;

    always_comb begin
        status          = 6'h00;
        status[FLAG_C]  = c;
        status[FLAG_Z]  = (r == 16'h0000);
        status[FLAG_N]  = r[15];
        status[FLAG_V]  = v;
        status[FLAG_P]  = ~^r;
        status[FLAG_AC] = ac;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Register-file ALU sequencer: accept command, read operands, iterate ALU, write back.
// Latency 3 cycles single-pass, 2+N for shift class, 2 for illegal opcodes.
// cmd_ready only in IDLE; ext loads outside IDLE are dropped.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int CNTW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [4:0]      cmd_op,
    input  logic [2:0]      cmd_rd,
    input  logic [2:0]      cmd_ra,
    input  logic [2:0]      cmd_rb,
    input  logic [CNTW-1:0] cmd_cnt,
    input  logic            ext_we,
    input  logic [2:0]      ext_addr,
    input  logic [15:0]     ext_data,
    output logic            done_valid,
    output logic [15:0]     done_result,
    output logic [5:0]      done_status,
    output logic            done_err,
    output logic [5:0]      flags
);

    state_t          state;
    logic [4:0]      op_q;
    logic [2:0]      rd_q;
    logic [2:0]      ra_q;
    logic [2:0]      rb_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] iter_q;
    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic            carry;
    logic [15:0]     regs [NREGS];
    logic [15:0]     alu_result;
    logic [5:0]      alu_status;
    logic            last_iter;

    function automatic logic [15:0] reg_rd(input logic [2:0] idx);
        return (int'(idx) < NREGS) ? regs[idx] : 16'h0000;
    endfunction

    assign cmd_ready = (state == ST_IDLE);
    assign last_iter = !op_q[4] || (iter_q == CNTW'(1));

    alu u_alu (
        .f      (op_q),
        .a      (op_a),
        .b      (op_b),
        .cin    (carry),
        .result (alu_result),
        .status (alu_status)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            cnt_q       <= '0;
            iter_q      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            carry       <= 1'b0;
            flags       <= '0;
            done_valid  <= 1'b0;
            done_result <= '0;
            done_status <= '0;
            done_err    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ext_we && (int'(ext_addr) < NREGS)) begin
                        regs[ext_addr] <= ext_data;
                    end
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        ra_q  <= cmd_ra;
                        rb_q  <= cmd_rb;
                        cnt_q <= cmd_cnt;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    op_a   <= reg_rd(ra_q);
                    op_b   <= reg_rd(rb_q);
                    carry  <= flags[FLAG_C];
                    iter_q <= (cnt_q == '0) ? CNTW'(1) : cnt_q;
                    if (op_legal(op_q)) begin
                        state <= ST_EXEC;
                    end else begin
                        done_valid  <= 1'b1;
                        done_err    <= 1'b1;
                        done_result <= '0;
                        done_status <= flags;
                        state       <= ST_WRITE;
                    end
                end
                ST_EXEC: begin
                    // Commit happens on the edge leaving EXEC, so a reset before it discards everything.
                    if (last_iter) begin
                        if (int'(rd_q) < NREGS) begin
                            regs[rd_q] <= alu_result;
                        end
                        flags       <= alu_status;
                        done_valid  <= 1'b1;
                        done_err    <= 1'b0;
                        done_result <= alu_result;
                        done_status <= alu_status;
                        state       <= ST_WRITE;
                    end else begin
                        op_a   <= alu_result;
                        carry  <= alu_status[FLAG_C];
                        iter_q <= iter_q - CNTW'(1);
                    end
                end
                ST_WRITE: begin
                    done_valid <= 1'b0;
                    done_err   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scenarios plus randomized commands against a behavioural register/flag model.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_ra;
    logic [2:0]  cmd_rb;
    logic [3:0]  cmd_cnt;
    logic        ext_we;
    logic [2:0]  ext_addr;
    logic [15:0] ext_data;
    logic        done_valid;
    logic [15:0] done_result;
    logic [5:0]  done_status;
    logic        done_err;
    logic [5:0]  flags;

    alu_sequencer #(.NREGS(8), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_cnt(cmd_cnt),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .done_valid(done_valid), .done_result(done_result), .done_status(done_status),
        .done_err(done_err), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total;
    int         passed;
    int         mregs [8];
    logic [5:0] mflags;
    logic [4:0] legal_ops [18] = '{OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_AND, OP_OR, OP_XOR,
                                   OP_NOT, OP_SHL, OP_SHR, OP_SAL, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Behavioural model: what the op should produce from register values and the flag register.
    function automatic void ref_op(input logic [4:0] op, input int a, input int b, input logic [5:0] fl,
                                   input int cnt, output int res, output logic [5:0] st,
                                   output bit err, output int lat);
        int  full;
        int  s;
        int  bv;
        int  ci;
        int  x;
        int  old;
        int  n;
        bit  c;
        bit  nc;
        bit  cf;
        bit  vf;
        bit  acf;
        logic [15:0] r16;
        err = 1'b0;
        cf = 1'b0; vf = 1'b0; acf = 1'b0;
        res = 0;
        c = fl[5];
        ci = c ? 1 : 0;
        lat = 3;
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                bv   = (op == OP_INC) ? 1 : b;
                if (op != OP_ADC) ci = 0;
                full = a + bv + ci;
                cf   = full > 65535;
                res  = full % 65536;
                acf  = ((a % 16) + (bv % 16) + ci) > 15;
                s    = sx(a) + sx(bv) + ci;
                vf   = (s > 32767) || (s < -32768);
            end
            OP_SUB, OP_SBB, OP_DEC: begin
                bv   = (op == OP_DEC) ? 1 : b;
                if (op != OP_SBB) ci = 0;
                full = a - bv - ci;
                cf   = full < 0;
                res  = (full + 65536) % 65536;
                acf  = ((a % 16) - (bv % 16) - ci) < 0;
                s    = sx(a) - sx(bv) - ci;
                vf   = (s > 32767) || (s < -32768);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = 65535 - a;
            OP_SHL, OP_SHR, OP_SAL, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
                n = (cnt == 0) ? 1 : cnt;
                lat = 2 + n;
                x = a;
                for (int i = 0; i < n; i++) begin
                    old = x;
                    case (op)
                        OP_SHL, OP_SAL: begin cf = x[15]; x = (x * 2) % 65536; end
                        OP_SHR: begin cf = x[0]; x = x / 2; end
                        OP_SAR: begin cf = x[0]; x = x / 2 + (old[15] ? 32768 : 0); end
                        OP_ROL: begin cf = x[15]; x = (x * 2) % 65536 + (cf ? 1 : 0); end
                        OP_ROR: begin cf = x[0]; x = x / 2 + (cf ? 32768 : 0); end
                        OP_RCL: begin nc = x[15]; x = (x * 2) % 65536 + (c ? 1 : 0); cf = nc; end
                        default: begin nc = x[0]; x = x / 2 + (c ? 32768 : 0); cf = nc; end
                    endcase
                    c  = cf;
                    vf = (x[15] != old[15]);
                end
                res = x;
            end
            default: begin
                err = 1'b1;
                lat = 2;
            end
        endcase
        r16 = res[15:0];
        if (err) st = fl;
        else     st = {cf, (res == 0), r16[15], vf, ($countones(r16) % 2 == 0), acf};
    endfunction

    task automatic ext_load(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        ext_we = 1'b1; ext_addr = addr; ext_data = data;
        @(negedge clk);
        ext_we = 1'b0;
        mregs[addr] = int'(data);
    endtask

    task automatic run_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [3:0] cnt, input bit with_ld,
                           input logic [2:0] la, input logic [15:0] ld, input string tag,
                           output logic [15:0] got_res, output logic [5:0] got_st, output int got_lat);
        int         res;
        logic [5:0] st;
        bit         err;
        int         lat;
        int         k;
        @(negedge clk);
        chk({tag, "/ready"}, 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_cnt = cnt;
        ext_we = with_ld; ext_addr = la; ext_data = ld;
        if (with_ld) mregs[la] = int'(ld);
        ref_op(op, mregs[ra], mregs[rb], mflags, int'(cnt), res, st, err, lat);
        @(negedge clk);
        cmd_valid = 1'b0; ext_we = 1'b0;
        k = 1;
        while (!done_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        got_res = done_result; got_st = done_status; got_lat = k;
        chk({tag, "/latency"}, 32'(k), 32'(lat));
        chk({tag, "/result"}, 32'(done_result), 32'(res));
        chk({tag, "/status"}, 32'(done_status), 32'(st));
        chk({tag, "/err"}, 32'(done_err), 32'(err));
        if (!err) begin
            mregs[rd] = res;
            mflags = st;
        end
        chk({tag, "/flags"}, 32'(flags), 32'(mflags));
        @(negedge clk);
        chk({tag, "/pulse_end"}, 32'(done_valid), 32'h0);
        chk({tag, "/ready_next"}, 32'(cmd_ready), 32'h1);
    endtask

    // Observe a register non-destructively: OR it with itself into itself.
    task automatic peek(input logic [2:0] r, input logic [15:0] exp, input string tag);
        logic [15:0] gr;
        logic [5:0]  gs;
        int          gl;
        run_cmd(OP_OR, r, r, r, 4'd0, 1'b0, 3'd0, 16'h0, tag, gr, gs, gl);
        chk({tag, "/value"}, 32'(gr), 32'(exp));
    endtask

    initial begin
        logic [15:0] gr;
        logic [5:0]  gs;
        logic [5:0]  fl_before;
        int          gl;
        int          k;
        int          accepts;
        int          res;
        logic [5:0]  st;
        bit          err;
        int          lat;
        logic [4:0]  rop;

        total = 0; passed = 0;
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        mflags = 6'h00;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_cnt = '0; ext_we = 1'b0; ext_addr = '0; ext_data = '0;
        repeat (3) @(negedge clk);
        chk("reset/done_valid", 32'(done_valid), 32'h0);
        chk("reset/done_result", 32'(done_result), 32'h0);
        chk("reset/done_status", 32'(done_status), 32'h0);
        chk("reset/done_err", 32'(done_err), 32'h0);
        chk("reset/flags", 32'(flags), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset/ready", 32'(cmd_ready), 32'h1);

        // Signed overflow into 0x8000
        ext_load(3'd1, 16'h7FFF);
        ext_load(3'd2, 16'h0001);
        run_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 4'd0, 1'b0, 3'd0, 16'h0, "add_ovf", gr, gs, gl);
        chk("add_ovf/lat3", 32'(gl), 32'd3);
        chk("add_ovf/res8000", 32'(gr), 32'h8000);
        chk("add_ovf/st0D", 32'(gs), 32'h0D);
        peek(3'd3, 16'h8000, "add_ovf/r3");

        // Carry out, then ADC consumes the carry flag
        ext_load(3'd1, 16'hFFFF);
        ext_load(3'd2, 16'h0001);
        run_cmd(OP_ADD, 3'd4, 3'd1, 3'd2, 4'd0, 1'b0, 3'd0, 16'h0, "add_carry", gr, gs, gl);
        chk("add_carry/res0", 32'(gr), 32'h0000);
        chk("add_carry/st33", 32'(gs), 32'h33);
        run_cmd(OP_ADC, 3'd7, 3'd5, 3'd6, 4'd0, 1'b0, 3'd0, 16'h0, "adc", gr, gs, gl);
        chk("adc/res1", 32'(gr), 32'h0001);

        // Multi-iteration shift and carry-through rotate
        ext_load(3'd1, 16'h0F0F);
        run_cmd(OP_SHL, 3'd1, 3'd1, 3'd0, 4'd4, 1'b0, 3'd0, 16'h0, "shl4", gr, gs, gl);
        chk("shl4/lat6", 32'(gl), 32'd6);
        chk("shl4/resF0F0", 32'(gr), 32'hF0F0);
        chk("shl4/c0", 32'(gs[FLAG_C]), 32'h0);
        ext_load(3'd2, 16'hFFFF);
        ext_load(3'd3, 16'h0001);
        run_cmd(OP_ADD, 3'd0, 3'd2, 3'd3, 4'd0, 1'b0, 3'd0, 16'h0, "set_c", gr, gs, gl);
        ext_load(3'd4, 16'h8000);
        run_cmd(OP_RCL, 3'd4, 3'd4, 3'd0, 4'd1, 1'b0, 3'd0, 16'h0, "rcl1", gr, gs, gl);
        chk("rcl1/res1", 32'(gr), 32'h0001);
        chk("rcl1/c1", 32'(gs[FLAG_C]), 32'h1);

        // Illegal opcode leaves rd and flags alone
        fl_before = flags;
        run_cmd(5'b00000, 3'd2, 3'd1, 3'd1, 4'd0, 1'b0, 3'd0, 16'h0, "illegal", gr, gs, gl);
        chk("illegal/status_eq_flags", 32'(gs), 32'(fl_before));
        chk("illegal/flags_kept", 32'(flags), 32'(fl_before));
        peek(3'd2, 16'hFFFF, "illegal/r2");

        // Hold cmd_valid and ext_we across a long rotate
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ROR; cmd_rd = 3'd5; cmd_ra = 3'd1; cmd_rb = 3'd0; cmd_cnt = 4'd8;
        accepts = cmd_ready ? 1 : 0;
        ref_op(OP_ROR, mregs[1], mregs[0], mflags, 8, res, st, err, lat);
        @(negedge clk);
        ext_we = 1'b1; ext_addr = 3'd6; ext_data = 16'hABCD;
        k = 1;
        while (!done_valid && k < 40) begin
            chk("hold/ready_low", 32'(cmd_ready), 32'h0);
            if (cmd_ready) accepts++;
            @(negedge clk);
            k++;
        end
        chk("hold/ready_low_write", 32'(cmd_ready), 32'h0);
        cmd_valid = 1'b0; ext_we = 1'b0;
        chk("hold/one_accept", 32'(accepts), 32'd1);
        chk("hold/lat10", 32'(k), 32'd10);
        chk("hold/result", 32'(done_result), 32'(res));
        chk("hold/status", 32'(done_status), 32'(st));
        mregs[5] = res; mflags = st;
        @(negedge clk);
        peek(3'd6, 16'(mregs[6]), "hold/r6_not_loaded");

        // Reset in the middle of EXEC
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ROR; cmd_rd = 3'd2; cmd_ra = 3'd4; cmd_rb = 3'd0; cmd_cnt = 4'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/done_valid", 32'(done_valid), 32'h0);
        chk("rst_mid/done_result", 32'(done_result), 32'h0);
        chk("rst_mid/done_status", 32'(done_status), 32'h0);
        chk("rst_mid/done_err", 32'(done_err), 32'h0);
        chk("rst_mid/flags", 32'(flags), 32'h0);
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        mflags = 6'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid/ready", 32'(cmd_ready), 32'h1);
        peek(3'd2, 16'h0000, "rst_mid/r2");

        // Randomized commands, occasionally with a coincident ext load or an illegal opcode
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) ext_load(3'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 9) == 0) rop = 5'($urandom_range(0, 31));
            else rop = legal_ops[$urandom_range(0, 17)];
            run_cmd(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    16'($urandom), "rand", gr, gs, gl);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
